// File: rtl/rv32i_types.sv
// Shared types and constants for the instruction-fetch responder and its line store.
package rv32i_types;

    localparam int LINE_BITS = 256;
    localparam int BEAT_BITS = 64;
    localparam int OFFSET_W  = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        REQ     = 3'd2,
        REFILL  = 3'd3,
        RESPOND = 3'd4
    } imem_resp_state_t;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [2:0]           word);
        return line[{word, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/imem_line_array.sv
// Direct-mapped flop store: per-set valid, tag and 256-bit line, combinational read.
module imem_line_array
    import rv32i_types::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - OFFSET_W - IDX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     i_index,
    input  logic                 i_we,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [LINE_BITS-1:0] i_line,
    output logic                 o_valid,
    output logic [TAG_W-1:0]     o_tag,
    output logic [LINE_BITS-1:0] o_line
);

    logic [SETS-1:0]      r_valid;
    logic [TAG_W-1:0]     r_tag  [SETS];
    logic [LINE_BITS-1:0] r_data [SETS];

    // Valid bits are the only array state cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= {SETS{1'b0}};
        end else if (i_we) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    // Tag and data are written on the final refill beat; contents are don't-care until valid.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_index]  <= i_tag;
            r_data[i_index] <= i_line;
        end
    end

    assign o_valid = r_valid[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_line  = r_data[i_index];

endmodule

// File: rtl/imem_responder_checker.sv
// Protocol assertions for the fetch responder; observes only, drives nothing.
module imem_responder_checker
    import rv32i_types::*;
(
    input logic             clk,
    input logic             rst,
    input imem_resp_state_t state,
    input logic             hit,
    input logic [31:0]      imem_addr,
    input logic [3:0]       imem_rmask,
    input logic             bmem_rvalid,
    input logic [31:0]      bmem_raddr,
    input logic [31:0]      bmem_addr
);

    a_rmask_legal: assert property (@(posedge clk) disable iff (!rst)
        (imem_rmask == 4'b0000) || (imem_rmask == 4'b1111));

    a_addr_aligned: assert property (@(posedge clk) disable iff (!rst)
        (imem_rmask != 4'b0000) |-> (imem_addr[1:0] == 2'b00));

    a_req_when_busy: assert property (@(posedge clk) disable iff (!rst)
        (imem_rmask != 4'b0000) |->
            !((state == REQ) || (state == REFILL) || ((state == COMPARE) && !hit)));

    a_raddr_match: assert property (@(posedge clk) disable iff (!rst)
        ((state == REFILL) && bmem_rvalid) |-> (bmem_raddr == bmem_addr));

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: direct-mapped read-only line store refilled by 4x64-bit bursts.
module imem_responder
    import rv32i_types::*;
#(
    parameter int SETS       = 16,
    parameter int LINE_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    input  logic        bmem_ready,
    input  logic [31:0] bmem_raddr,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFFSET_W - IDX_W;
    localparam int CNT_W = $clog2(LINE_BEATS);

    imem_resp_state_t     r_state, w_next_state;
    logic [31:2]          r_req_addr;
    logic [31:0]          r_bmem_addr;
    logic [CNT_W-1:0]     r_cnt;
    logic [LINE_BITS-1:0] r_buf;

    logic [IDX_W-1:0]     w_index;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_arr_valid;
    logic [TAG_W-1:0]     w_arr_tag;
    logic [LINE_BITS-1:0] w_arr_line;
    logic [LINE_BITS-1:0] w_fill_line;
    logic                 w_hit, w_req, w_beat_ok, w_last;
    logic                 w_accept, w_resp;
    logic [31:0]          w_rdata;

    assign w_index   = r_req_addr[OFFSET_W +: IDX_W];
    assign w_tag     = r_req_addr[31 -: TAG_W];
    assign w_hit     = w_arr_valid && (w_arr_tag == w_tag);
    assign w_req     = (imem_rmask != 4'b0000);
    assign w_beat_ok = (r_state == REFILL) && bmem_rvalid && (bmem_raddr == r_bmem_addr);
    assign w_last    = w_beat_ok && (r_cnt == CNT_W'(LINE_BEATS - 1));

    // Merge the incoming beat into the assembly buffer; on the last beat this is the whole line.
    always_comb begin
        w_fill_line = r_buf;
        w_fill_line[{r_cnt, 6'd0} +: BEAT_BITS] = bmem_rdata;
    end

    imem_line_array #(.SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_line_array (
        .clk     (clk),
        .rst     (rst),
        .i_index (w_index),
        .i_we    (w_last),
        .i_tag   (w_tag),
        .i_line  (w_fill_line),
        .o_valid (w_arr_valid),
        .o_tag   (w_arr_tag),
        .o_line  (w_arr_line)
    );

    // Next-state and response decode; a new request is only taken in IDLE or a response cycle.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_resp       = 1'b0;
        w_rdata      = 32'h0000_0000;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = COMPARE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            COMPARE: begin
                if (w_hit) begin
                    w_resp       = 1'b1;
                    w_rdata      = line_word(w_arr_line, r_req_addr[4:2]);
                    w_accept     = w_req;
                    w_next_state = w_req ? COMPARE : IDLE;
                end else begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (bmem_ready) begin
                    w_next_state = REFILL;
                end else begin
                    w_next_state = REQ;
                end
            end
            REFILL: begin
                if (w_last) begin
                    w_next_state = RESPOND;
                end else begin
                    w_next_state = REFILL;
                end
            end
            RESPOND: begin
                w_resp       = 1'b1;
                w_rdata      = line_word(w_arr_line, r_req_addr[4:2]);
                w_accept     = w_req;
                w_next_state = w_req ? COMPARE : IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request address, refill address and beat counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_addr  <= 30'h0000_0000;
            r_bmem_addr <= 32'h0000_0000;
            r_cnt       <= {CNT_W{1'b0}};
        end else begin
            if (w_accept) begin
                r_req_addr <= imem_addr[31:2];
            end
            if ((r_state == COMPARE) && !w_hit) begin
                r_bmem_addr <= {r_req_addr[31:OFFSET_W], 5'b00000};
            end
            if ((r_state == REQ) || w_last) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (w_beat_ok) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Beat assembly buffer; only meaningful while a refill is in progress.
    always_ff @(posedge clk) begin
        if (w_beat_ok) begin
            r_buf <= w_fill_line;
        end
    end

    assign imem_resp  = w_resp;
    assign imem_rdata = w_rdata;
    assign bmem_read  = (r_state == REQ);
    assign bmem_addr  = r_bmem_addr;

    imem_responder_checker u_checker (
        .clk         (clk),
        .rst         (rst),
        .state       (r_state),
        .hit         (w_hit),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .bmem_rvalid (bmem_rvalid),
        .bmem_raddr  (bmem_raddr),
        .bmem_addr   (r_bmem_addr)
    );

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected words queued at request, checked at each resp.
module tb_imem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb [$];
    logic [31:0] exp_w;

    imem_responder #(.SETS(16), .LINE_BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Backing-memory contents: beat k of the line at address a.
    function automatic logic [63:0] beat_val(input logic [31:0] a, input int k);
        if (a == 32'h6000_0000 && k == 0) return 64'h0000_0013_0000_0093;
        return {(a + 32'(k) * 32'h0101_0101) ^ 32'hA5A5_0000, a ^ ~32'(k)};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [63:0] b;
        b = beat_val({a[31:5], 5'b00000}, int'(a[4:3]));
        return a[2] ? b[63:32] : b[31:0];
    endfunction

    // Response monitor: every resp must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && imem_resp) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 64'(imem_resp), 64'd0);
            end else begin
                exp_w = sb.pop_front();
                check_eq("resp_data", 64'(imem_rdata), 64'(exp_w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a);
        imem_addr  = a;
        imem_rmask = 4'b1111;
        sb.push_back(exp_word(a));
    endtask

    task automatic drive_beats(input logic [31:0] line, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = line;
            bmem_rdata  = beat_val(line, k);
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
    endtask

    // One fetch from IDLE; on a miss, serve the refill after 'hold' not-ready cycles.
    task automatic fetch(input logic [31:0] a, input bit exp_miss, input int hold,
                         input bit has_nxt, input logic [31:0] nxt);
        logic [31:0] line;
        line = {a[31:5], 5'b00000};
        @(negedge clk);
        issue(a);
        @(negedge clk);
        imem_rmask = 4'b0000;
        if (!exp_miss) begin
            check_eq("hit_resp", 64'(imem_resp), 64'd1);
            return;
        end
        check_eq("miss_no_resp", 64'(imem_resp), 64'd0);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            check_eq("req_read_held", 64'(bmem_read), 64'd1);
            check_eq("req_addr_stable", 64'(bmem_addr), 64'(line));
            check_eq("req_no_resp", 64'(imem_resp), 64'd0);
            bmem_rvalid = (i == 2);
            bmem_raddr  = line;
            bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        check_eq("req_read", 64'(bmem_read), 64'd1);
        check_eq("req_addr", 64'(bmem_addr), 64'(line));
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready = 1'b0;
        check_eq("refill_read_low", 64'(bmem_read), 64'd0);
        drive_beats(line, 0, 3);
        check_eq("resp_after_last_beat", 64'(imem_resp), 64'd1);
        if (has_nxt) begin
            issue(nxt);
            @(negedge clk);
            imem_rmask = 4'b0000;
            check_eq("respond_follow_hit", 64'(imem_resp), 64'd1);
        end
        @(negedge clk);
        check_eq("resp_single_pulse", 64'(imem_resp), 64'd0);
    endtask

    initial begin
        rst         = 1'b0;
        imem_addr   = 32'h0000_0000;
        imem_rmask  = 4'b0000;
        bmem_ready  = 1'b0;
        bmem_raddr  = 32'h0000_0000;
        bmem_rdata  = 64'h0;
        bmem_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_resp", 64'(imem_resp), 64'd0);
        check_eq("reset_rdata", 64'(imem_rdata), 64'd0);
        check_eq("reset_read", 64'(bmem_read), 64'd0);
        check_eq("reset_baddr", 64'(bmem_addr), 64'd0);
        rst = 1'b1;

        // First fill with a stalled backing memory and a spurious beat during REQ.
        fetch(32'h6000_0000, 1'b1, 5, 1'b0, 32'h0);

        // Three back-to-back hits, each issued in the previous resp cycle.
        @(negedge clk);
        issue(32'h6000_0004);
        @(negedge clk);
        check_eq("b2b_resp0", 64'(imem_resp), 64'd1);
        issue(32'h6000_0008);
        @(negedge clk);
        check_eq("b2b_resp1", 64'(imem_resp), 64'd1);
        issue(32'h6000_000C);
        @(negedge clk);
        check_eq("b2b_resp2", 64'(imem_resp), 64'd1);
        imem_rmask = 4'b0000;
        @(negedge clk);
        check_eq("b2b_end", 64'(imem_resp), 64'd0);

        // Conflict on index 0, with a same-line request in the RESPOND cycle.
        fetch(32'h6000_0200, 1'b1, 0, 1'b1, 32'h6000_0204);
        fetch(32'h6000_0000, 1'b1, 1, 1'b0, 32'h0);
        fetch(32'h6000_001C, 1'b0, 0, 1'b0, 32'h0);

        // Asynchronous reset while a hit response is being driven.
        @(negedge clk);
        issue(32'h6000_0008);
        @(posedge clk);
        #2;
        imem_rmask = 4'b0000;
        check_eq("pre_reset_resp", 64'(imem_resp), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("async_resp_drop", 64'(imem_resp), 64'd0);
        check_eq("async_rdata_zero", 64'(imem_rdata), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset while a refill request is outstanding.
        @(negedge clk);
        issue(32'h6000_0040);
        @(negedge clk);
        imem_rmask = 4'b0000;
        @(negedge clk);
        check_eq("req_before_reset", 64'(bmem_read), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_read_drop", 64'(bmem_read), 64'd0);
        check_eq("async_baddr_zero", 64'(bmem_addr), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;

        // Reset after two of four beats, then stale beats, then a clean refill.
        @(negedge clk);
        issue(32'h6000_0020);
        @(negedge clk);
        imem_rmask = 4'b0000;
        @(negedge clk);
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_ready = 1'b0;
        drive_beats(32'h6000_0020, 0, 1);
        #2;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        drive_beats(32'h6000_0020, 2, 3);
        check_eq("stale_no_resp", 64'(imem_resp), 64'd0);
        @(negedge clk);
        check_eq("stale_idle_read", 64'(bmem_read), 64'd0);
        fetch(32'h6000_0020, 1'b1, 0, 1'b0, 32'h0);
        fetch(32'h6000_0000, 1'b1, 0, 1'b0, 32'h0);
        fetch(32'h6000_0024, 1'b0, 0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch memory interface. Accepts word fetch requests (`imem_addr`/`imem_rmask`) from the fetch front end and returns `imem_resp`/`imem_rdata`.
- Contains a small direct-mapped, read-only line store built from flops.
- On a miss, refills a 256-bit line from backing memory as a 4-beat, 64-bit burst.
- Sits between the fetch unit and the backing-memory arbiter.

Parameters:
- SETS, 16, number of direct-mapped lines; power of two, minimum 2.
- LINE_BEATS, 4, backing-memory beats per 256-bit line; fixed at 4 for this line size.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- imem_addr  input  32  fetch byte address; bits [1:0] must be 0.
- imem_rmask  input  4  nonzero = request this cycle; the only legal nonzero value is 4'b1111.
- imem_rdata  output  32  instruction word; valid only when imem_resp=1.
- imem_resp  output  1  one-cycle pulse completing the oldest accepted request.
- bmem_addr  output  32  line-aligned refill address, {req_addr[31:5],5'b0}.
- bmem_read  output  1  refill request; held high until sampled with bmem_ready=1.
- bmem_ready  input  1  backing memory accepts bmem_read this cycle.
- bmem_raddr  input  32  line address of the returning beat; must equal the outstanding bmem_addr.
- bmem_rdata  input  64  refill beat data.
- bmem_rvalid  input  1  bmem_rdata is valid this cycle.

Behaviour:
- Address split:
  - word = addr[4:2]
  - index = addr[5 +: log2(SETS)]
  - tag = addr[31 : 5+log2(SETS)]
  - Word w of a line occupies bits [32w +: 32]. Beat k fills bits [64k +: 64].
- State machine: IDLE, COMPARE, REQ, REFILL, RESPOND.
  - IDLE: if rmask != 0, latch addr into req_addr, then go to COMPARE.
  - COMPARE, hit (valid[index] && tag match):
    - Drive imem_resp=1 and imem_rdata = the selected word. Hit latency is 1 cycle after the request.
    - If a new request is present this same cycle, latch it and stay in COMPARE (back-to-back hits, one word per cycle).
    - Otherwise go to IDLE.
  - COMPARE, miss: go to REQ.
  - REQ: bmem_read=1 and bmem_addr valid. On bmem_ready=1, go to REFILL with the beat counter at 0.
  - REFILL: each bmem_rvalid with a matching bmem_raddr writes beat[cnt] and increments cnt. On the LINE_BEATS-th beat:
    - write the line;
    - set valid[index] and tag[index];
    - go to RESPOND.
  - RESPOND: imem_resp=1 with the word taken from the freshly written line; a request in this cycle is latched and the FSM goes to COMPARE, otherwise to IDLE.
- Protocol rules:
  - The requester issues a new request only in IDLE or in the cycle imem_resp=1.
  - A request in COMPARE-miss, REQ or REFILL is a protocol violation. Flag it with a simulation assertion; the RTL ignores it.
  - imem_resp never asserts without a prior accepted request. Exactly one response per accepted request, in order.
  - Responses are never cancelled. A requester that redirects (branch mispredict) discards them itself.
- Boundary conditions:
  - bmem_rvalid outside REFILL is ignored; this covers beats of a burst abandoned by reset.
  - bmem_rvalid with a mismatched bmem_raddr is ignored, with an assertion.
  - A refill overwrites the line at the same index, so the victim is lost (no write-back; the store is read-only).
  - A request to the same line as the one just refilled, presented in the RESPOND cycle, hits in COMPARE.
  - rmask values other than 0 and 4'b1111, or addr[1:0] != 0, trigger an assertion.
- Reset (rst=0, asynchronous):
  - state=IDLE; all valid bits=0; beat counter=0.
  - imem_resp=0, imem_rdata=0, bmem_read=0, bmem_addr=0.
  - Data and tag arrays are not reset.
  - Reset during REFILL abandons the burst, and the line is not marked valid.

Decomposition:
- Shared package (rv32i_types):
  - imem_resp_state_t enum (IDLE, COMPARE, REQ, REFILL, RESPOND);
  - constants LINE_BITS=256, BEAT_BITS=64, OFFSET_W=5.
- One sub-module, imem_line_array, holds per-set valid, tag and data:
  - inputs: index, write enable, tag in, line in;
  - outputs: valid, tag and line for the read index (combinational read);
  - valid clears on rst.
- Beat assembly and the FSM stay in imem_responder.

Test Plan:
- Reset, then request addr=0x6000_0000 with rmask=1111:
  - bmem_addr=0x6000_0000 with bmem_read held until ready;
  - 4 beats with beat0=0x0000_0013_0000_0093;
  - imem_rdata=0x0000_0093 with imem_resp a single pulse, one cycle after the last beat.
- After that fill, requests 0x6000_0004, 0x6000_0008 and 0x6000_000C issued back-to-back in each resp cycle produce 3 consecutive resp cycles, with words 0x0000_0013, beat1[31:0] and beat1[63:32].
- Conflict at SETS=16: 0x6000_0000 filled, then 0x6000_0200 (same index 0, different tag):
  - the miss refills at bmem_addr=0x6000_0200;
  - re-requesting 0x6000_0000 misses again.
- Hold bmem_ready=0 for 5 cycles in REQ: bmem_read and bmem_addr stay stable and no resp occurs. Inject a spurious bmem_rvalid during REQ: the array is unchanged.
- Assert rst=0 after 2 of 4 beats, release, then drive the remaining 2 stale beats:
  - the stale beats are ignored;
  - the next request to the same line misses and refills.
- Assert rst=0 asynchronously between clock edges: imem_resp and bmem_read drop immediately, without waiting for a clock edge.
